// File: rtl/bitwise_result_stage.sv
// bitwise_result_stage
//   Registered output stage behind the ALU bitwise unit. Each accepted result
//   is captured with its instruction code and its zero/negative/parity flags.
//   A two-entry skid buffer (main + skid) keeps full throughput under
//   backpressure while cutting the combinational path from the bitwise unit.
//   A retired-result counter and a sticky zero flag are kept alongside.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_Y, in_inst            result and instruction code from the bitwise unit
//   out_valid/out_ready      downstream handshake
//   out_Y, out_inst          registered result and instruction code
//   out_zero/neg/parity      flags captured when the entry was written
//   flag_clr, sticky_zero    clear / sticky "a zero result was retired"
//   result_count             retired results, modulo 2^CNT_WIDTH
module bitwise_result_stage #(
    parameter int BUS_WIDTH  = 8,
    parameter int INST_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_Y,
    input  logic [INST_WIDTH-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  out_Y,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_parity,
    input  logic                  flag_clr,
    output logic                  sticky_zero,
    output logic [CNT_WIDTH-1:0]  result_count
);

    typedef struct packed {
        logic [BUS_WIDTH-1:0]  y;
        logic [INST_WIDTH-1:0] inst;
        logic                  zero;
        logic                  neg;
        logic                  parity;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_ent;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid;

    // Flags are derived from the incoming result at capture time so the
    // output side never has a reduction tree behind its registers.
    always_comb begin
        in_ent.y      = in_Y;
        in_ent.inst   = in_inst;
        in_ent.zero   = (in_Y == '0);
        in_ent.neg    = in_Y[BUS_WIDTH-1];
        in_ent.parity = ^in_Y;
    end

    // Handshakes are gated by rst so nothing is accepted or retired in a
    // reset cycle, whatever state the stage was in.
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY) && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Entries only change on a load, so out_* hold their last value while
    // the stage is empty or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_ent;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_ent;
        end
    end

    assign out_Y      = main_q.y;
    assign out_inst   = main_q.inst;
    assign out_zero   = main_q.zero;
    assign out_neg    = main_q.neg;
    assign out_parity = main_q.parity;

    // A zero retiring in the same cycle as flag_clr leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_zero  <= 1'b0;
            result_count <= '0;
        end else begin
            sticky_zero <= (sticky_zero && !flag_clr) || (out_fire && main_q.zero);
            if (out_fire) result_count <= result_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitwise_result_stage.sv
module tb_bitwise_result_stage;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, flag_clr;
    logic [7:0] in_Y;
    logic [2:0] in_inst;

    logic       in_ready, out_valid, out_zero, out_neg, out_parity, sticky_zero;
    logic [7:0] out_Y, result_count;
    logic [2:0] out_inst;

    logic       d4_in_ready, d4_out_valid, d4_zero, d4_neg, d4_parity, d4_sticky;
    logic [7:0] d4_Y;
    logic [2:0] d4_inst;
    logic [3:0] d4_count;

    always #5 clk = ~clk;

    bitwise_result_stage #(.BUS_WIDTH(8), .INST_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_Y(in_Y), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_Y(out_Y), .out_inst(out_inst), .out_zero(out_zero), .out_neg(out_neg),
        .out_parity(out_parity), .flag_clr(flag_clr), .sticky_zero(sticky_zero),
        .result_count(result_count)
    );

    // Narrow-counter copy driven by the same stimulus, for the wrap check.
    bitwise_result_stage #(.BUS_WIDTH(8), .INST_WIDTH(3), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_Y(in_Y), .in_inst(in_inst), .out_valid(d4_out_valid), .out_ready(out_ready),
        .out_Y(d4_Y), .out_inst(d4_inst), .out_zero(d4_zero), .out_neg(d4_neg),
        .out_parity(d4_parity), .flag_clr(flag_clr), .sticky_zero(d4_sticky),
        .result_count(d4_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an order-preserving buffer of capacity 2, one-cycle
    // visibility, plus the last retired entry for the idle output value.
    logic [14:0] q[$];
    logic [14:0] last_ent = '0;
    int          m_cnt = 0;
    bit          m_sticky = 0;

    function automatic logic [14:0] mk(input logic [7:0] y, input logic [2:0] inst);
        bit z, n, p;
        z = (y == 8'd0);
        n = (y >= 8'd128);
        p = ($countones(y) % 2) == 1;
        return {y, inst, z, n, p};
    endfunction

    always @(negedge clk) begin
        logic [14:0] exp_o;
        bit          ov, ir, fo, fi;
        ov    = !rst && (q.size() > 0);
        ir    = !rst && (q.size() < 2);
        exp_o = (q.size() > 0) ? q[0] : last_ent;
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("out_data", 32'({out_Y, out_inst, out_zero, out_neg, out_parity}), 32'(exp_o));
        chk("d4_out_data", 32'({d4_Y, d4_inst, d4_zero, d4_neg, d4_parity}), 32'(exp_o));
        chk("d4_handshake", 32'({d4_in_ready, d4_out_valid, d4_sticky}), 32'({ir, ov, m_sticky}));
        chk("result_count", 32'(result_count), 32'(m_cnt % 256));
        chk("d4_result_count", 32'(d4_count), 32'(m_cnt % 16));
        chk("sticky_zero", 32'(sticky_zero), 32'(m_sticky));
        if (rst) begin
            q.delete();
            last_ent = '0;
            m_cnt    = 0;
            m_sticky = 0;
        end else begin
            fo = ov && out_ready;
            fi = ir && in_valid;
            m_sticky = (m_sticky && !flag_clr) || (fo && q[0][2]);
            if (fo) begin
                last_ent = q.pop_front();
                m_cnt++;
            end
            if (fi) q.push_back(mk(in_Y, in_inst));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the item on the input until it is accepted; leaves in_valid high
    // so consecutive pushes stream back to back.
    task automatic push(input logic [7:0] y, input logic [2:0] inst);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_Y     = y;
        in_inst  = inst;
        n        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: item %0h not accepted within 50 cycles", y);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_Y = '0; in_inst = '0;
        out_ready = 1'b0; flag_clr = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // single zero transfer
        out_ready = 1'b1;
        push(8'h00, 3'b000);
        in_valid = 1'b0;
        repeat (2) step();

        // backpressure fill, rejected third push, drain in order
        out_ready = 1'b0;
        push(8'h81, 3'd1);
        push(8'h7F, 3'd2);
        in_Y = 8'h55; in_inst = 3'd3;
        repeat (3) step();
        out_ready = 1'b1;
        push(8'h55, 3'd3);
        in_valid = 1'b0;
        repeat (4) step();

        // zero retiring from FULL with flag_clr and a blocked input
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        out_ready = 1'b0;
        push(8'h00, 3'd4);
        push(8'h33, 3'd5);
        in_Y = 8'h44; in_inst = 3'd6;
        out_ready = 1'b1; flag_clr = 1'b1;
        step();
        flag_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("sticky_set_wins", 32'(sticky_zero), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();

        // reset from FULL with count 5
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i), 3'(i));
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        push(8'hA1, 3'd1);
        push(8'hA2, 3'd2);
        @(negedge clk);
        chk("count_before_reset", 32'(result_count), 32'd5);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("count_after_reset", 32'(result_count), 32'd0);
        chk("valid_after_reset", 32'(out_valid), 32'd0);

        // streaming 00..0F
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i), 3'(i));
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("stream_count", 32'(result_count), 32'd16);

        // 17 retirements wrap the 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) push(8'($urandom), 3'($urandom));
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("wrap_cnt4", 32'(d4_count), 32'd1);
        chk("wrap_cnt8", 32'(result_count), 32'd17);

        // random traffic with occasional resets
        repeat (600) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_Y      = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            in_inst   = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
